// File: rtl/top_pkg.sv
// ----------------------------------------------------------------------------
// top_pkg: shared count width, parameter defaults and saturating increment.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns / 1ps
`default_nettype none

package top_pkg;

   localparam int COUNT_W             = 16;
   localparam int DEFAULT_GATE_CYCLES = 1000;
   localparam int DEFAULT_STAGES      = 5;

   // Adds inc to v, sticking at all-ones instead of wrapping.
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                  input logic               inc);
      if (inc && (v != {COUNT_W{1'b1}})) begin
         return v + COUNT_W'(1);
      end
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ring_osc.sv
// ----------------------------------------------------------------------------
// ring_osc: NAND-gated inverter ring; output is static 0 while osc_en = 0.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns / 1ps
`default_nettype none

module ring_osc
   import top_pkg::*;
#(
   parameter int STAGES             = DEFAULT_STAGES,
   parameter int SIM_STAGE_DELAY_NS = 5
) (
   input  logic osc_en,
   output logic osc_out
);

   // node[0] is the NAND output; the NAND counts as one of the STAGES
   // inversions, so STAGES-1 (even) inverters close the loop.
   (* keep = "true", dont_touch = "true" *) wire node [STAGES];

`ifdef SYNTHESIS
   assign node[0] = ~(osc_en & node[STAGES-1]);
   for (genvar i = 1; i < STAGES; i++) begin : g_inv
      assign node[i] = ~node[i-1];
   end
`else
   assign #(SIM_STAGE_DELAY_NS) node[0] = ~(osc_en & node[STAGES-1]);
   for (genvar i = 1; i < STAGES; i++) begin : g_inv
      assign #(SIM_STAGE_DELAY_NS) node[i] = ~node[i-1];
   end
`endif

   // node[1] sits one inversion after the NAND, so it settles to 0 when stopped.
   assign osc_out = node[1];

endmodule

`default_nettype wire

// File: rtl/top.sv
// ----------------------------------------------------------------------------
// top: ring-oscillator frequency meter; counts ring rises per GATE_CYCLES window.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns / 1ps
`default_nettype none

module top
   import top_pkg::*;
#(
   parameter int STAGES             = DEFAULT_STAGES,
   parameter int GATE_CYCLES        = DEFAULT_GATE_CYCLES,
   parameter int SIM_STAGE_DELAY_NS = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   output logic [COUNT_W-1:0] out
);

   localparam logic [COUNT_W-1:0] LAST_CYCLE = COUNT_W'(GATE_CYCLES - 1);

   logic               osc_en;
   logic               ring_out;
   (* async_reg = "true" *) logic s1;
   (* async_reg = "true" *) logic s2;
   logic               s3;
   logic               rise;
   logic               win_end;
   logic [COUNT_W-1:0] win_cnt;
   logic [COUNT_W-1:0] edge_cnt;

   assign osc_en = enable & ~rst;

   ring_osc #(
      .STAGES             (STAGES),
      .SIM_STAGE_DELAY_NS (SIM_STAGE_DELAY_NS)
   ) u_ring (
      .osc_en  (osc_en),
      .osc_out (ring_out)
   );

   // Two-flop synchronizer plus one history flop for rise detection.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= ring_out;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise    = s2 & ~s3;
   assign win_end = (win_cnt == LAST_CYCLE);

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         win_cnt  <= '0;
         edge_cnt <= '0;
      end else if (win_end) begin
         win_cnt  <= '0;
         edge_cnt <= '0;
      end else begin
         win_cnt  <= win_cnt + COUNT_W'(1);
         edge_cnt <= sat_inc(edge_cnt, rise);
      end
   end

   // A rise seen in the last window cycle still belongs to that window.
   always_ff @(posedge clk) begin
      if (rst) begin
         out <= '0;
      end else if (enable && win_end) begin
         out <= sat_inc(edge_cnt, rise);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_top.sv
// ----------------------------------------------------------------------------
// tb_top: directed self-checking bench for the ring-oscillator meter.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns / 1ps
`default_nettype none

module tb_top;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        enable  = 1'b0;
   logic        en_g2   = 1'b0;
   logic        rst_sat = 1'b1;
   logic        en_sat  = 1'b0;
   logic [15:0] out_main;
   logic [15:0] out_g2;
   logic [15:0] out_alt;
   logic [15:0] out_all;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   top #(.STAGES(5), .GATE_CYCLES(1000), .SIM_STAGE_DELAY_NS(5)) dut (
      .clk(clk), .rst(rst), .enable(enable), .out(out_main));

   top #(.STAGES(5), .GATE_CYCLES(2), .SIM_STAGE_DELAY_NS(5)) dut_g2 (
      .clk(clk), .rst(rst), .enable(en_g2), .out(out_g2));

   top #(.STAGES(5), .GATE_CYCLES(65535), .SIM_STAGE_DELAY_NS(1)) dut_alt (
      .clk(clk), .rst(rst_sat), .enable(en_sat), .out(out_alt));

   top #(.STAGES(5), .GATE_CYCLES(65535), .SIM_STAGE_DELAY_NS(1)) dut_all (
      .clk(clk), .rst(rst_sat), .enable(en_sat), .out(out_all));

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst    = 1'b1;
      enable = 1'b0;
      en_g2  = 1'b0;
      tick(3);
      tests_run++;
      if (out_main !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_out: out=%0d required 0", out_main);
      end
      tests_run++;
      if (dut.ring_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ring_static: ring=%b required 0", dut.ring_out);
      end
      tests_run++;
      if (out_g2 !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_out_g2: out=%0d required 0", out_g2);
      end
      // reset must win over enable
      enable = 1'b1;
      tick(2);
      tests_run++;
      if (dut.win_cnt !== 16'd0 || dut.edge_cnt !== 16'd0 || out_main !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_priority: win=%0d edge=%0d out=%0d required 0/0/0",
                  dut.win_cnt, dut.edge_cnt, out_main);
      end
      enable = 1'b0;
      tick(5);
   endtask

   task automatic test_first_window;
      int bad = 0;
      rst    = 1'b0;
      enable = 1'b1;
      for (int k = 1; k <= 999; k++) begin
         tick(1);
         if (out_main !== 16'd0) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL first_window_hold: out nonzero in %0d early cycles, required 0", bad);
      end
      tick(1);
      tests_run++;
      if (!(out_main inside {[16'd199:16'd200]})) begin
         tests_failed++;
         $display("FAIL first_window_count: out=%0d required 199..200", out_main);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] hold;
      for (int w = 0; w < 2; w++) begin
         int bad = 0;
         hold = out_main;
         for (int k = 1; k <= 999; k++) begin
            tick(1);
            if (out_main !== hold) bad++;
         end
         tests_run++;
         if (bad != 0) begin
            tests_failed++;
            $display("FAIL steady_hold_%0d: out changed mid-window %0d times, required 0", w, bad);
         end
         tick(1);
         tests_run++;
         if (!(out_main inside {[16'd199:16'd201]})) begin
            tests_failed++;
            $display("FAIL steady_count_%0d: out=%0d required 199..201", w, out_main);
         end
      end
   endtask

   task automatic test_enable_drop;
      logic [15:0] hold;
      int          bad = 0;
      hold = out_main;
      tick(500);
      enable = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tick(1);
         if (out_main !== hold) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL drop_hold: out changed %0d times while disabled, required %0d kept",
                  bad, hold);
      end
      tests_run++;
      if (dut.win_cnt !== 16'd0 || dut.edge_cnt !== 16'd0 ||
          {dut.s1, dut.s2, dut.s3} !== 3'b000) begin
         tests_failed++;
         $display("FAIL drop_state_cleared: win=%0d edge=%0d sync=%b required 0/0/000",
                  dut.win_cnt, dut.edge_cnt, {dut.s1, dut.s2, dut.s3});
      end
      enable = 1'b1;
      bad    = 0;
      for (int k = 1; k <= 999; k++) begin
         tick(1);
         if (out_main !== hold) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL reenable_hold: out changed %0d times before window end, required 0", bad);
      end
      tick(1);
      tests_run++;
      if (!(out_main inside {[16'd199:16'd201]})) begin
         tests_failed++;
         $display("FAIL reenable_count: out=%0d required 199..201", out_main);
      end
   endtask

   task automatic test_rst_mid_window;
      int bad = 0;
      tick(400);
      tests_run++;
      if (out_main === 16'd0) begin
         tests_failed++;
         $display("FAIL rst_mid_precondition: out=%0d required nonzero", out_main);
      end
      rst = 1'b1;
      tick(1);
      tests_run++;
      if (out_main !== 16'd0) begin
         tests_failed++;
         $display("FAIL rst_mid_clear: out=%0d required 0", out_main);
      end
      tick(3);
      rst = 1'b0;
      for (int k = 1; k <= 999; k++) begin
         tick(1);
         if (out_main !== 16'd0) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL rst_mid_hold: out nonzero in %0d cycles after release, required 0", bad);
      end
      tick(1);
      tests_run++;
      if (!(out_main inside {[16'd199:16'd200]})) begin
         tests_failed++;
         $display("FAIL rst_mid_count: out=%0d required 199..200", out_main);
      end
   endtask

   task automatic test_gate2;
      logic [15:0] prev;
      int          bad_mid   = 0;
      int          bad_range = 0;
      int          sum       = 0;
      prev  = out_g2;
      en_g2 = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         tick(1);
         if (k % 2 == 1) begin
            if (out_g2 !== prev) bad_mid++;
         end else begin
            if (out_g2 > 16'd1) bad_range++;
            sum  += int'(out_g2);
            prev  = out_g2;
         end
      end
      tests_run++;
      if (bad_mid != 0) begin
         tests_failed++;
         $display("FAIL gate2_mid_window: out changed on %0d odd edges, required 0", bad_mid);
      end
      tests_run++;
      if (bad_range != 0) begin
         tests_failed++;
         $display("FAIL gate2_range: %0d windows reported >1, required 0", bad_range);
      end
      tests_run++;
      if (sum < 19 || sum > 21) begin
         tests_failed++;
         $display("FAIL gate2_total: summed out=%0d over 100 cycles, required 19..21", sum);
      end
   endtask

   task automatic test_saturation;
      rst_sat = 1'b1;
      en_sat  = 1'b1;
      tick(3);
      tests_run++;
      if (out_alt !== 16'd0 || out_all !== 16'd0) begin
         tests_failed++;
         $display("FAIL sat_reset: alt=%0d all=%0d required 0/0", out_alt, out_all);
      end
      rst_sat = 1'b0;
      force dut_alt.s2  = 1'b0;
      force dut_all.rise = 1'b1;
      for (int k = 2; k <= 65535; k++) begin
         tick(1);
         if (k % 2 == 0) force dut_alt.s2 = 1'b1;
         else            force dut_alt.s2 = 1'b0;
      end
      tests_run++;
      if (out_alt !== 16'd0 || out_all !== 16'd0) begin
         tests_failed++;
         $display("FAIL sat_hold: alt=%0d all=%0d required 0/0 before window end",
                  out_alt, out_all);
      end
      tick(1);
      tests_run++;
      if (out_alt !== 16'd32767) begin
         tests_failed++;
         $display("FAIL sat_alternate: out=%0d required 32767", out_alt);
      end
      tests_run++;
      if (out_all !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL sat_every_cycle: out=%h required ffff", out_all);
      end
      release dut_alt.s2;
      release dut_all.rise;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      fork
         test_saturation();
         begin
            test_reset();
            test_first_window();
            test_back_to_back();
            test_enable_drop();
            test_rst_mid_window();
            test_gate2();
         end
      join
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
